can_tx_scheduler: RTL

//  Schedules pending transmit buffers onto the single CAN-XL transmit path.

---
 rtl/can_tx_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/can_tx_scheduler.sv
// Transmit buffer scheduler: arbitrates pending buffers by lowest identifier, hands
// one frame at a time to the CAN-XL message processor and tracks done/fail/retry.
module can_tx_scheduler #(
   parameter int unsigned NUM_BUF   = 4,
   parameter int unsigned ID_W      = 11,
   parameter int unsigned RETRY_MAX = 16
) (
   input  logic                       clk,
   input  logic                       g_rst_n,
   input  logic [NUM_BUF-1:0]         buf_req,
   input  logic [NUM_BUF-1:0]         buf_abort,
   input  logic [NUM_BUF*ID_W-1:0]    buf_id,
   input  logic                       tx_success,
   input  logic                       re_tran,
   output logic                       msg_due_tx,
   output logic                       tx_buff_busy,
   output logic [$clog2(NUM_BUF)-1:0] tx_sel,
   output logic [NUM_BUF-1:0]         buf_done,
   output logic [NUM_BUF-1:0]         buf_fail,
   output logic [7:0]                 retry_cnt
);

   localparam int unsigned SEL_W = $clog2(NUM_BUF);

   typedef enum logic [1:0] {S_IDLE, S_SELECT, S_LOAD, S_PEND} state_e;

   state_e             state_q;
   logic [NUM_BUF-1:0] pending_q, pending_d;
   logic [NUM_BUF-1:0] done_q, done_d;
   logic [NUM_BUF-1:0] fail_q, fail_d;
   logic [SEL_W-1:0]   sel_q;
   logic [7:0]         retry_q, retry_inc;
   logic               due_q, busy_q, hold_q;

   logic               arb_found;
   logic [SEL_W-1:0]   arb_idx;
   logic [ID_W-1:0]    arb_id;
   logic [NUM_BUF-1:0] avail, sel_mask, held, abort_fail, cmp_clr;
   logic               in_flight, sel_abort, last_try, pend_ok, pend_drop;

   // Lowest identifier among pending, non-aborting buffers; strict compare keeps the lower index on ties
   always_comb begin
      avail     = pending_q & ~buf_abort;
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_id    = '0;
      for (int i = 0; i < int'(NUM_BUF); i++) begin
         if (avail[i] && (!arb_found || buf_id[i*ID_W +: ID_W] < arb_id)) begin
            arb_found = 1'b1;
            arb_idx   = SEL_W'(i);
            arb_id    = buf_id[i*ID_W +: ID_W];
         end
      end
   end

   // An in-flight frame is never cut: its abort is held until the processor reports back
   always_comb begin
      sel_mask   = NUM_BUF'(1) << sel_q;
      in_flight  = (state_q == S_LOAD) || (state_q == S_PEND);
      held       = in_flight ? sel_mask : '0;
      sel_abort  = |(buf_abort & held);
      last_try   = ({1'b0, retry_q} + 9'd1) == 9'(RETRY_MAX);
      retry_inc  = (retry_q >= 8'(RETRY_MAX)) ? retry_q : retry_q + 8'd1;
      pend_ok    = (state_q == S_PEND) && tx_success;
      pend_drop  = (state_q == S_PEND) && !tx_success && re_tran &&
                   (hold_q || sel_abort || last_try);
      cmp_clr    = (pend_ok || pend_drop) ? sel_mask : '0;
      abort_fail = buf_abort & (pending_q | buf_req) & ~held;
      done_d     = pend_ok ? sel_mask : '0;
      fail_d     = abort_fail | (pend_drop ? sel_mask : '0);
      // A fresh request survives the completion of the same buffer
      pending_d  = (pending_q & ~(buf_abort & ~held) & ~cmp_clr) | (buf_req & ~buf_abort);
   end

   always_ff @(posedge clk or negedge g_rst_n) begin
      if (!g_rst_n) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         done_q    <= '0;
         fail_q    <= '0;
         sel_q     <= '0;
         retry_q   <= '0;
         due_q     <= 1'b0;
         busy_q    <= 1'b0;
         hold_q    <= 1'b0;
      end else begin
         pending_q <= pending_d;
         done_q    <= done_d;
         fail_q    <= fail_d;
         due_q     <= 1'b0;
         if (sel_abort) hold_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (|pending_q) state_q <= S_SELECT;
            end
            S_SELECT: begin
               if (!arb_found) begin
                  state_q <= S_IDLE;
               end else begin
                  sel_q <= arb_idx;
                  if (arb_idx != sel_q) retry_q <= '0;
                  hold_q  <= 1'b0;
                  due_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               state_q <= S_PEND;
            end
            S_PEND: begin
               if (pend_ok || pend_drop) begin
                  busy_q  <= 1'b0;
                  retry_q <= '0;
                  hold_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (re_tran) begin
                  busy_q  <= 1'b0;
                  retry_q <= retry_inc;
                  state_q <= S_SELECT;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign msg_due_tx   = due_q;
   assign tx_buff_busy = busy_q;
   assign tx_sel       = sel_q;
   assign buf_done     = done_q;
   assign buf_fail     = fail_q;
   assign retry_cnt    = retry_q;

endmodule
